// File: rtl/register_file_sb.sv
// Register file with three combinational read ports, two write ports with
// same-cycle bypass, and a pending-write scoreboard driving issue/hazard control.
module register_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    input  logic [ADDR_W-1:0]   rs3,
    output logic [DATA_W-1:0]   rd1,
    output logic [DATA_W-1:0]   rd2,
    output logic [DATA_W-1:0]   rd3,
    output logic                hazard,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_rd,
    output logic                iss_ok,
    input  logic                wa_en,
    input  logic [ADDR_W-1:0]   wa_addr,
    input  logic [DATA_W-1:0]   wa_data,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_vec
);
    localparam int unsigned NUM_RD  = 3;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0]   regs    [NUM_REGS];
    logic [ADDR_W-1:0]   rs_addr [NUM_RD];
    logic [DATA_W-1:0]   rd_data [NUM_RD];
    logic [NUM_RD-1:0]   rs_hz;
    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] busy_nxt;

    assign rs_addr[0] = rs1;
    assign rs_addr[1] = rs2;
    assign rs_addr[2] = rs3;
    assign rd1        = rd_data[0];
    assign rd2        = rd_data[1];
    assign rd3        = rd_data[2];

    // Any enabled write port targeting a register resolves its pending write.
    always_comb begin
        clr = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            clr[i] = (wa_en && (wa_addr == ADDR_W'(i))) ||
                     (wb_en && (wb_addr == ADDR_W'(i)));
        end
    end

    // Read ports: hardwired zero, then port B bypass, port A bypass, storage.
    always_comb begin
        rd_data = '{default: '0};
        rs_hz   = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            if (ZERO_EN && (rs_addr[p] == '0)) begin
                rd_data[p] = '0;
            end else if (wb_en && (wb_addr == rs_addr[p])) begin
                rd_data[p] = wb_data;
            end else if (wa_en && (wa_addr == rs_addr[p])) begin
                rd_data[p] = wa_data;
            end else begin
                rd_data[p] = regs[rs_addr[p]];
            end
            rs_hz[p] = busy_vec[rs_addr[p]] && !clr[rs_addr[p]];
        end
    end

    assign hazard = |rs_hz;
    assign iss_ok = iss_en && (!busy_vec[iss_rd] || clr[iss_rd]);

    // A same-cycle issue re-marks the register even if a write clears it.
    always_comb begin
        busy_nxt = busy_vec & ~clr;
        if (iss_ok) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy_vec <= busy_nxt;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (!(ZERO_EN && (i == 0))) begin
                    if (wb_en && (wb_addr == ADDR_W'(i))) begin
                        regs[i] <= wb_data;
                    end else if (wa_en && (wa_addr == ADDR_W'(i))) begin
                        regs[i] <= wa_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: directed scenarios plus random traffic
// against a behavioural model; also a 64-bit / 32-register instance.
`timescale 1ns/1ps
module tb_register_file_sb;
    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 16;
    localparam int unsigned AW  = 4;
    localparam int unsigned XDW = 64;
    localparam int unsigned XNR = 32;
    localparam int unsigned XAW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rs1, rs2, rs3;
    logic [DW-1:0] rd1, rd2, rd3;
    logic          hazard;
    logic          iss_en;
    logic [AW-1:0] iss_rd;
    logic          iss_ok;
    logic          wa_en;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [NR-1:0] busy_vec;

    logic           x_rst;
    logic [XAW-1:0] x_rs1, x_rs2, x_rs3;
    logic [XDW-1:0] x_rd1, x_rd2, x_rd3;
    logic           x_hazard;
    logic           x_iss_en;
    logic [XAW-1:0] x_iss_rd;
    logic           x_iss_ok;
    logic           x_wa_en;
    logic [XAW-1:0] x_wa_addr;
    logic [XDW-1:0] x_wa_data;
    logic           x_wb_en;
    logic [XAW-1:0] x_wb_addr;
    logic [XDW-1:0] x_wb_data;
    logic [XNR-1:0] x_busy_vec;

    register_file_sb dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .hazard(hazard),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ok(iss_ok),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_vec(busy_vec)
    );

    register_file_sb #(.DATA_W(XDW), .NUM_REGS(XNR)) xdut (
        .clk(clk), .rst(x_rst), .rs1(x_rs1), .rs2(x_rs2), .rs3(x_rs3),
        .rd1(x_rd1), .rd2(x_rd2), .rd3(x_rd3), .hazard(x_hazard),
        .iss_en(x_iss_en), .iss_rd(x_iss_rd), .iss_ok(x_iss_ok),
        .wa_en(x_wa_en), .wa_addr(x_wa_addr), .wa_data(x_wa_data),
        .wb_en(x_wb_en), .wb_addr(x_wb_addr), .wb_data(x_wb_data),
        .busy_vec(x_busy_vec)
    );

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] rd3;
        logic          hazard;
        logic          iss_ok;
        logic [NR-1:0] busy;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a register is resolved by any write to it this cycle.
    function automatic logic m_clr(input logic [AW-1:0] a);
        return (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        if (wa_en && wa_addr == a) return wa_data;
        return m_regs[a];
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model.
    task automatic apply();
        exp_t e;
        logic ok;
        e.rd1    = m_read(rs1);
        e.rd2    = m_read(rs2);
        e.rd3    = m_read(rs3);
        e.hazard = (m_busy[rs1] && !m_clr(rs1)) || (m_busy[rs2] && !m_clr(rs2)) ||
                   (m_busy[rs3] && !m_clr(rs3));
        ok       = iss_en && (!m_busy[iss_rd] || m_clr(iss_rd));
        e.iss_ok = ok;
        e.busy   = m_busy;
        sbq.push_back(e);
        if (rst) begin
            m_busy = '0;
            foreach (m_regs[i]) m_regs[i] = '0;
        end else begin
            if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
            for (int i = 0; i < int'(NR); i++) begin
                if (m_clr(AW'(i))) m_busy[i] = 1'b0;
            end
            if (ok && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic idle();
        rst = 1'b0; iss_en = 1'b0; wa_en = 1'b0; wb_en = 1'b0;
    endtask

    task automatic go();
        apply();
        #2;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a queued prediction is compared at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_rd1",    64'(rd1),      64'(e.rd1));
                chk("sb_rd2",    64'(rd2),      64'(e.rd2));
                chk("sb_rd3",    64'(rd3),      64'(e.rd3));
                chk("sb_hazard", 64'(hazard),   64'(e.hazard));
                chk("sb_iss_ok", 64'(iss_ok),   64'(e.iss_ok));
                chk("sb_busy",   64'(busy_vec), 64'(e.busy));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        idle(); rst = 1'b1;
        rs1 = '0; rs2 = '0; rs3 = '0; iss_rd = '0;
        wa_addr = '0; wa_data = '0; wb_addr = '0; wb_data = '0;
        x_rst = 1'b1; x_iss_en = 1'b0; x_wa_en = 1'b0; x_wb_en = 1'b0;
        x_rs1 = '0; x_rs2 = '0; x_rs3 = '0; x_iss_rd = '0;
        x_wa_addr = '0; x_wa_data = '0; x_wb_addr = '0; x_wb_data = '0;
        next();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_busy = '0;
        rst = 1'b0;

        rs1 = 4'd3; rs2 = 4'd9; rs3 = 4'd15; go();
        chk("reset_rd1", 64'(rd1), 64'd0);
        chk("reset_hazard", 64'(hazard), 64'd0);
        chk("reset_busy", 64'(busy_vec), 64'd0);
        next();

        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEADBEEF; go();
        chk("bypass_a", 64'(rd1), 64'hDEADBEEF);
        next();
        idle(); go();
        chk("stored_a", 64'(rd1), 64'hDEADBEEF);
        next();

        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h22; rs2 = 4'd5; go();
        chk("both_bypass", 64'(rd2), 64'h22);
        next();
        idle(); go();
        chk("both_stored", 64'(rd2), 64'h22);
        next();

        iss_en = 1'b1; iss_rd = 4'd7; go();
        chk("issue_ok", 64'(iss_ok), 64'd1);
        next();
        rs3 = 4'd7; go();
        chk("busy7_set", 64'(busy_vec[7]), 64'd1);
        chk("hazard7", 64'(hazard), 64'd1);
        chk("waw_reject", 64'(iss_ok), 64'd0);
        next();
        idle(); wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h55; go();
        chk("hazard_resolved", 64'(hazard), 64'd0);
        chk("rd3_bypass", 64'(rd3), 64'h55);
        next();
        idle(); go();
        chk("busy7_clear", 64'(busy_vec[7]), 64'd0);
        next();

        iss_en = 1'b1; iss_rd = 4'd4; go();
        next();
        wa_en = 1'b1; wa_addr = 4'd4; wa_data = 32'hA5A5_0F0F; go();
        chk("set_over_clr_ok", 64'(iss_ok), 64'd1);
        next();
        idle(); rs1 = 4'd4; go();
        chk("set_over_clr_data", 64'(rd1), 64'hA5A5_0F0F);
        chk("set_over_clr_busy", 64'(busy_vec[4]), 64'd1);
        next();

        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_rd = 4'd0; rs1 = 4'd0; go();
        chk("zero_rd", 64'(rd1), 64'd0);
        chk("zero_iss_ok", 64'(iss_ok), 64'd1);
        next();
        idle(); go();
        chk("zero_busy", 64'(busy_vec[0]), 64'd0);
        chk("zero_rd_after", 64'(rd1), 64'd0);
        next();

        wa_en = 1'b1; wa_addr = 4'd2; wa_data = 32'h1234_5678;
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h9999_0000;
        iss_en = 1'b1; iss_rd = 4'd9; go();
        next();
        idle(); rs1 = 4'd2; rs2 = 4'd9; go();
        chk("preload_r2", 64'(rd1), 64'h1234_5678);
        chk("preload_busy9", 64'(busy_vec[9]), 64'd1);
        next();
        rst = 1'b1; wa_en = 1'b1; wa_addr = 4'd2; wa_data = 32'h0BAD_0BAD; go();
        next();
        idle(); rs1 = 4'd2; rs2 = 4'd9; rs3 = 4'd5; go();
        chk("rst_rd1", 64'(rd1), 64'd0);
        chk("rst_rd2", 64'(rd2), 64'd0);
        chk("rst_rd3", 64'(rd3), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        next();

        repeat (400) begin
            rst     = ($urandom_range(0, 49) == 0);
            iss_en  = 1'($urandom_range(0, 1));
            iss_rd  = AW'($urandom_range(0, NR - 1));
            wa_en   = 1'($urandom_range(0, 1));
            wa_addr = AW'($urandom_range(0, NR - 1));
            wa_data = $urandom;
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NR - 1));
            wb_data = $urandom;
            rs1     = AW'($urandom_range(0, NR - 1));
            rs2     = AW'($urandom_range(0, NR - 1));
            rs3     = ($urandom_range(0, 2) == 0) ? iss_rd : AW'($urandom_range(0, NR - 1));
            go();
            next();
        end
        idle();
        next();
        next();
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        x_rst = 1'b0; x_rs1 = 5'd3; x_rs2 = 5'd31; x_rs3 = 5'd0; #2;
        chk("x_reset_rd1", x_rd1, 64'd0);
        chk("x_reset_busy", 64'(x_busy_vec), 64'd0);
        chk("x_reset_hazard", 64'(x_hazard), 64'd0);
        next();
        x_wa_en = 1'b1; x_wa_addr = 5'd3; x_wa_data = 64'hDEADBEEF_CAFEF00D;
        x_wb_en = 1'b1; x_wb_addr = 5'd31; x_wb_data = 64'h8000_0000_0000_0001; #2;
        chk("x_bypass_a", x_rd1, 64'hDEADBEEF_CAFEF00D);
        chk("x_bypass_b", x_rd2, 64'h8000_0000_0000_0001);
        next();
        x_wa_en = 1'b0; x_wb_en = 1'b0; x_iss_en = 1'b1; x_iss_rd = 5'd31; #2;
        chk("x_stored_a", x_rd1, 64'hDEADBEEF_CAFEF00D);
        chk("x_stored_b", x_rd2, 64'h8000_0000_0000_0001);
        chk("x_iss_ok", 64'(x_iss_ok), 64'd1);
        next();
        x_iss_en = 1'b0; #2;
        chk("x_busy31", 64'(x_busy_vec), 64'h8000_0000);
        chk("x_hazard31", 64'(x_hazard), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
